// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode 0 master sequencer driving an external parallel-load shift register.
module spi_master_ctrl #(
  parameter int DATA_LEN = 8,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                busy,
  output logic                done,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                sclk,
  output logic                cs_n,
  input  logic                miso,
  output logic                sr_load_en,
  output logic                sr_shift_en,
  output logic [DATA_LEN-1:0] sr_d_in,
  output logic                sr_serial_in,
  input  logic                sr_serial_out,
  input  logic [DATA_LEN-1:0] sr_d_out
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_LEN + 1);
  typedef enum logic [1:0] {IDLE, LEAD, HIGH, LOW} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic tick, accept, finish, rise, fall;
  logic unused_mosi;
  assign unused_mosi = sr_serial_out;
  // The load cycle does not count toward the lead time, so MOSI is stable a full half-period.
  assign tick = !sr_load_en && cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state || state == IDLE) ? '0 : cnt + CW'(!sr_load_en);
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LEAD : IDLE;
      LEAD:    state_nxt = tick ? HIGH : LEAD;
      HIGH:    state_nxt = tick ? LOW : HIGH;
      default: state_nxt = tick ? (bit_cnt == BW'(DATA_LEN) ? IDLE : HIGH) : LOW;
    endcase
  end
  always_comb begin
    accept = state == IDLE && start;
    finish = state == LOW && tick && bit_cnt == BW'(DATA_LEN);
    fall   = state == HIGH && tick;
    rise   = state != HIGH && state_nxt == HIGH;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      cs_n         <= 1'b1;
      sclk         <= 1'b0;
      sr_load_en   <= 1'b0;
      sr_shift_en  <= 1'b0;
      sr_d_in      <= '0;
      sr_serial_in <= 1'b0;
      rx_data      <= '0;
      bit_cnt      <= '0;
    end else begin
      busy         <= accept | (busy & ~finish);
      done         <= finish;
      cs_n         <= accept ? 1'b0 : finish ? 1'b1 : cs_n;
      sclk         <= rise ? 1'b1 : fall ? 1'b0 : sclk;
      sr_load_en   <= accept;
      sr_shift_en  <= fall;
      sr_d_in      <= accept ? tx_data : sr_d_in;
      sr_serial_in <= rise ? miso : sr_serial_in;
      rx_data      <= finish ? sr_d_out : rx_data;
      bit_cnt      <= accept ? '0 : bit_cnt + BW'(fall);
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench for spi_master_ctrl with behavioural shift registers and a SPI slave.
module tb_spi_master_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] tx_data = '0;
  logic slave_mode = 1'b0, slave_load = 1'b0;
  logic busy8, done8, sclk8, cs8, ld8, sh8, si8, so8, miso8, sclk8_q;
  logic [7:0] rx8, din8, sr8, slave_sr;
  logic busy16, done16, sclk16, cs16, ld16, sh16, si16, so16;
  logic [15:0] rx16, din16, sr16;
  int checks = 0, errors = 0;
  int rises, falls, done_k;
  bit timing_ok, ctl_ok, rst_ok;
  logic [15:0] mosi;

  always #5 clk = ~clk;

  spi_master_ctrl #(.DATA_LEN(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data[7:0]), .busy(busy8), .done(done8),
    .rx_data(rx8), .sclk(sclk8), .cs_n(cs8), .miso(miso8), .sr_load_en(ld8), .sr_shift_en(sh8),
    .sr_d_in(din8), .sr_serial_in(si8), .sr_serial_out(so8), .sr_d_out(sr8));

  spi_master_ctrl #(.DATA_LEN(16), .CLK_DIV(3)) dut16 (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy16), .done(done16),
    .rx_data(rx16), .sclk(sclk16), .cs_n(cs16), .miso(so16), .sr_load_en(ld16), .sr_shift_en(sh16),
    .sr_d_in(din16), .sr_serial_in(si16), .sr_serial_out(so16), .sr_d_out(sr16));

  always @(posedge clk) sr8 <= ld8 ? din8 : sh8 ? {sr8[6:0], si8} : sr8;
  always @(posedge clk) sr16 <= ld16 ? din16 : sh16 ? {sr16[14:0], si16} : sr16;
  assign so8 = sr8[7];
  assign so16 = sr16[15];
  // Slave shifts its next bit out just after each SCLK falling edge.
  always @(posedge clk) begin
    sclk8_q  <= sclk8;
    slave_sr <= slave_load ? 8'h5A : (sclk8_q && !sclk8) ? {slave_sr[6:0], 1'b0} : slave_sr;
  end
  assign miso8 = slave_mode ? slave_sr[7] : so8;

  task automatic run(input bit wide, input logic [15:0] tx, input bit hold, input int glitch_k,
                     input int rst_k);
    int d;
    bit prev, s, dn, cs, bz, so;
    d = wide ? 3 : 2;
    prev = 1'b0;
    rises = 0; falls = 0; timing_ok = 1'b1; ctl_ok = 1'b1; done_k = -1; mosi = '0; rst_ok = 1'b1;
    tx_data = tx;
    start = 1'b1;
    for (int k = 0; k <= 250; k++) begin
      @(negedge clk);
      s = wide ? sclk16 : sclk8;
      dn = wide ? done16 : done8;
      cs = wide ? cs16 : cs8;
      bz = wide ? busy16 : busy8;
      so = wide ? so16 : so8;
      if (s && !prev) begin
        timing_ok &= (k == 1 + d + 2 * d * rises);
        mosi = {mosi[14:0], so};
        rises++;
      end
      if (!s && prev) begin
        timing_ok &= (k == 1 + 2 * d + 2 * d * falls);
        falls++;
      end
      prev = s;
      if (dn) begin
        ctl_ok &= cs && !bz;
        done_k = k;
        break;
      end
      ctl_ok &= !cs && bz;
      if (k == rst_k) begin
        #2 rst = 1'b1;
        #1 rst_ok = cs8 === 1'b1 && sclk8 === 1'b0 && busy8 === 1'b0;
        break;
      end
      start = hold || k == glitch_k - 1;
      tx_data = (k == glitch_k - 1) ? 16'h0000 : tx;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done8); end
    checks++; if (cs8 !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b exp 1", cs8); end
    checks++; if (sclk8 !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", sclk8); end
    checks++; if ({ld8, sh8, si8} !== 3'b000) begin errors++; $display("FAIL reset_sr_ctl got %b exp 000", {ld8, sh8, si8}); end
    checks++; if (din8 !== 8'h00) begin errors++; $display("FAIL reset_d_in got %h exp 00", din8); end
    checks++; if (rx8 !== 8'h00) begin errors++; $display("FAIL reset_rx got %h exp 00", rx8); end
    checks++; if ({cs16, sclk16, busy16} !== 3'b100) begin errors++; $display("FAIL reset_wide got %b exp 100", {cs16, sclk16, busy16}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback();
    run(1'b0, 16'h00B3, 1'b0, -100, -1);
    checks++; if (rises !== 8) begin errors++; $display("FAIL loop_pulses got %0d exp 8", rises); end
    checks++; if (!timing_ok) begin errors++; $display("FAIL loop_edges got %b exp 1", timing_ok); end
    checks++; if (done_k !== 35) begin errors++; $display("FAIL loop_done_edge got %0d exp 35", done_k); end
    checks++; if (rx8 !== 8'hB3) begin errors++; $display("FAIL loop_rx got %h exp b3", rx8); end
    checks++; if (!ctl_ok) begin errors++; $display("FAIL loop_cs_busy got %b exp 1", ctl_ok); end
    checks++; if (mosi[7:0] !== 8'hB3) begin errors++; $display("FAIL loop_mosi got %h exp b3", mosi[7:0]); end
    @(negedge clk);
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL loop_done_pulse got %b exp 0", done8); end
  endtask

  task automatic test_slave();
    slave_load = 1'b1;
    @(negedge clk);
    slave_load = 1'b0;
    slave_mode = 1'b1;
    run(1'b0, 16'h00FF, 1'b0, -100, -1);
    slave_mode = 1'b0;
    checks++; if (rx8 !== 8'h5A) begin errors++; $display("FAIL slave_rx got %h exp 5a", rx8); end
    checks++; if (mosi[7:0] !== 8'hFF) begin errors++; $display("FAIL slave_mosi got %h exp ff", mosi[7:0]); end
    checks++; if (done_k !== 35) begin errors++; $display("FAIL slave_done_edge got %0d exp 35", done_k); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignore_start();
    run(1'b0, 16'h00B3, 1'b0, 10, -1);
    checks++; if (rises !== 8) begin errors++; $display("FAIL ign_pulses got %0d exp 8", rises); end
    checks++; if (rx8 !== 8'hB3) begin errors++; $display("FAIL ign_rx got %h exp b3", rx8); end
    checks++; if (done_k !== 35) begin errors++; $display("FAIL ign_done_edge got %0d exp 35", done_k); end
    checks++; if (!ctl_ok) begin errors++; $display("FAIL ign_busy got %b exp 1", ctl_ok); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run(1'b0, 16'h0081, 1'b1, -100, -1);
    checks++; if (done_k !== 35) begin errors++; $display("FAIL b2b_done1 got %0d exp 35", done_k); end
    checks++; if (rx8 !== 8'h81) begin errors++; $display("FAIL b2b_rx1 got %h exp 81", rx8); end
    checks++; if (cs8 !== 1'b1) begin errors++; $display("FAIL b2b_gap_cs_n got %b exp 1", cs8); end
    run(1'b0, 16'h007E, 1'b0, -100, -1);
    checks++; if (done_k + 36 !== 71) begin errors++; $display("FAIL b2b_done2 got %0d exp 71", done_k + 36); end
    checks++; if (rx8 !== 8'h7E) begin errors++; $display("FAIL b2b_rx2 got %h exp 7e", rx8); end
    checks++; if (!ctl_ok) begin errors++; $display("FAIL b2b_cs2 got %b exp 1", ctl_ok); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    run(1'b0, 16'h00B3, 1'b0, -100, 15);
    checks++; if (!rst_ok) begin errors++; $display("FAIL rst_mid_outputs got %b exp 1", rst_ok); end
    checks++; if (rx8 !== 8'h00) begin errors++; $display("FAIL rst_mid_rx got %h exp 00", rx8); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run(1'b0, 16'h003C, 1'b0, -100, -1);
    checks++; if (rx8 !== 8'h3C) begin errors++; $display("FAIL rst_after_rx got %h exp 3c", rx8); end
    checks++; if (done_k !== 35 || rises !== 8) begin errors++; $display("FAIL rst_after_timing got done %0d pulses %0d exp 35 8", done_k, rises); end
  endtask

  task automatic test_wide();
    repeat (120) @(negedge clk);
    run(1'b1, 16'hA5C3, 1'b0, -100, -1);
    checks++; if (rises !== 16) begin errors++; $display("FAIL wide_pulses got %0d exp 16", rises); end
    checks++; if (!timing_ok) begin errors++; $display("FAIL wide_edges got %b exp 1", timing_ok); end
    checks++; if (done_k !== 100) begin errors++; $display("FAIL wide_done_edge got %0d exp 100", done_k); end
    checks++; if (rx16 !== 16'hA5C3) begin errors++; $display("FAIL wide_rx got %h exp a5c3", rx16); end
    checks++; if (!ctl_ok) begin errors++; $display("FAIL wide_cs_busy got %b exp 1", ctl_ok); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
